// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder reused LSB-first over WIDTH cycles.
// Optional signed-overflow output Ofl is enabled by defining SERIAL_ADD_OVF_EN.

module fulladder1 (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
`ifdef SERIAL_ADD_OVF_EN
  output logic             Ofl,
`endif
  output logic             Cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;

  fulladder1 u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // The counter stops at WIDTH-1 rather than incrementing, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      Ofl     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B;
            r_carry <= Cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_acc   <= {w_s, r_acc[WIDTH-1:1]};
          r_carry <= w_co;
          r_a     <= {1'b0, r_a[WIDTH-1:1]};
          r_b     <= {1'b0, r_b[WIDTH-1:1]};
          if (w_last) begin
            Sum  <= {w_s, r_acc[WIDTH-1:1]};
            Cout <= w_co;
`ifdef SERIAL_ADD_OVF_EN
            // r_carry here is the carry into the MSB.
            Ofl  <= r_carry ^ w_co;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=16 and WIDTH=5.
// Define SERIAL_ADD_OVF_EN to also check Ofl.

module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start16, start5;
  logic [15:0] A16, B16, Sum16;
  logic [4:0]  A5, B5, Sum5;
  logic C16, C5, busy16, busy5, done16, done5, Cout16, Cout5;
`ifdef SERIAL_ADD_OVF_EN
  logic Ofl16, Ofl5;
`endif

  int total = 0;
  int bad   = 0;
  logic [17:0] q16[$];
  logic [6:0]  q5[$];
  logic [15:0] prev16 = '0;
  logic [4:0]  prev5  = '0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(A16), .B(B16), .Cin(C16),
    .busy(busy16), .done(done16), .Sum(Sum16),
`ifdef SERIAL_ADD_OVF_EN
    .Ofl(Ofl16),
`endif
    .Cout(Cout16)
  );

  serial_add_ctrl #(.WIDTH(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .A(A5), .B(B5), .Cin(C5),
    .busy(busy5), .done(done5), .Sum(Sum5),
`ifdef SERIAL_ADD_OVF_EN
    .Ofl(Ofl5),
`endif
    .Cout(Cout5)
  );

  // {ofl, cout, sum}; ofl = carry into MSB xor carry out of MSB
  function automatic logic [17:0] exp16(input logic [15:0] a, b, input logic c);
    logic [16:0] f;
    logic [15:0] l;
    f = {1'b0, a} + {1'b0, b} + {16'd0, c};
    l = {1'b0, a[14:0]} + {1'b0, b[14:0]} + {15'd0, c};
    return {l[15] ^ f[16], f};
  endfunction

  function automatic logic [6:0] exp5(input logic [4:0] a, b, input logic c);
    logic [5:0] f;
    logic [4:0] l;
    f = {1'b0, a} + {1'b0, b} + {5'd0, c};
    l = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, c};
    return {l[4] ^ f[5], f};
  endfunction

  // Called at a negedge; drives start, then checks every cycle through DONE+1.
  // noise: scramble operands mid-run, re-pulse start (A=FFFF at cycle 4) and hold start in DONE.
  task automatic do_op16(input logic [15:0] a, b, input logic c, input bit noise);
    logic [17:0] e;
    A16 = a; B16 = b; C16 = c; start16 = 1'b1;
    q16.push_back(exp16(a, b, c));
    for (int cyc = 1; cyc <= 17; cyc++) begin
      @(negedge clk);
      total++;
      if (busy16 !== (cyc <= 16)) begin bad++; $display("FAIL busy16 cyc=%0d got=%b exp=%b", cyc, busy16, (cyc <= 16)); end
      total++;
      if (done16 !== (cyc == 17)) begin bad++; $display("FAIL done16 cyc=%0d got=%b exp=%b", cyc, done16, (cyc == 17)); end
      if (cyc <= 16) begin
        total++;
        if (Sum16 !== prev16) begin bad++; $display("FAIL hold16 cyc=%0d got=%h exp=%h", cyc, Sum16, prev16); end
      end
      if (done16 === 1'b1) begin
        total++;
        if (q16.size() == 0) begin
          bad++; $display("FAIL extra_done16 cyc=%0d got=done exp=no_done", cyc);
        end else begin
          e = q16.pop_front();
          if ({Cout16, Sum16} !== e[16:0]) begin
            bad++; $display("FAIL sum16 a=%h b=%h c=%b got=%b_%h exp=%b_%h", a, b, c, Cout16, Sum16, e[16], e[15:0]);
          end
`ifdef SERIAL_ADD_OVF_EN
          total++;
          if (Ofl16 !== e[17]) begin bad++; $display("FAIL ofl16 a=%h b=%h got=%b exp=%b", a, b, Ofl16, e[17]); end
`endif
          prev16 = e[15:0];
        end
      end
      if (noise) begin
        A16 = 16'($urandom); B16 = 16'($urandom); C16 = 1'($urandom);
        start16 = (cyc == 4 || cyc == 17) ? 1'b1 : 1'($urandom);
        if (cyc == 4) A16 = 16'hFFFF;
      end else begin
        start16 = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (busy16 !== 1'b0 || done16 !== 1'b0) begin bad++; $display("FAIL post16 got=%b%b exp=00", busy16, done16); end
    start16 = 1'b0;
    $display("op16 a=%h b=%h cin=%b sum=%h cout=%b", a, b, c, Sum16, Cout16);
  endtask

  task automatic do_op5(input logic [4:0] a, b, input logic c, input bit noise);
    logic [6:0] e;
    A5 = a; B5 = b; C5 = c; start5 = 1'b1;
    q5.push_back(exp5(a, b, c));
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      total++;
      if (busy5 !== (cyc <= 5)) begin bad++; $display("FAIL busy5 cyc=%0d got=%b exp=%b", cyc, busy5, (cyc <= 5)); end
      total++;
      if (done5 !== (cyc == 6)) begin bad++; $display("FAIL done5 cyc=%0d got=%b exp=%b", cyc, done5, (cyc == 6)); end
      if (cyc <= 5) begin
        total++;
        if (Sum5 !== prev5) begin bad++; $display("FAIL hold5 cyc=%0d got=%h exp=%h", cyc, Sum5, prev5); end
      end
      if (done5 === 1'b1) begin
        total++;
        if (q5.size() == 0) begin
          bad++; $display("FAIL extra_done5 cyc=%0d got=done exp=no_done", cyc);
        end else begin
          e = q5.pop_front();
          if ({Cout5, Sum5} !== e[5:0]) begin
            bad++; $display("FAIL sum5 a=%h b=%h c=%b got=%b_%h exp=%b_%h", a, b, c, Cout5, Sum5, e[5], e[4:0]);
          end
`ifdef SERIAL_ADD_OVF_EN
          total++;
          if (Ofl5 !== e[6]) begin bad++; $display("FAIL ofl5 a=%h b=%h got=%b exp=%b", a, b, Ofl5, e[6]); end
`endif
          prev5 = e[4:0];
        end
      end
      if (noise) begin
        A5 = 5'($urandom); B5 = 5'($urandom); C5 = 1'($urandom);
        start5 = (cyc == 6) ? 1'b1 : 1'($urandom);
      end else begin
        start5 = 1'b0;
      end
    end
    @(negedge clk);
    total++;
    if (busy5 !== 1'b0 || done5 !== 1'b0) begin bad++; $display("FAIL post5 got=%b%b exp=00", busy5, done5); end
    start5 = 1'b0;
    $display("op5 a=%h b=%h cin=%b sum=%h cout=%b", a, b, c, Sum5, Cout5);
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++;
    if ({busy16, done16, Cout16, Sum16} !== 19'd0) begin bad++; $display("FAIL reset16 got=%b%b%b_%h exp=000_0000", busy16, done16, Cout16, Sum16); end
    total++;
    if ({busy5, done5, Cout5, Sum5} !== 8'd0) begin bad++; $display("FAIL reset5 got=%b%b%b_%h exp=000_00", busy5, done5, Cout5, Sum5); end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if ({Ofl16, Ofl5} !== 2'b00) begin bad++; $display("FAIL reset_ofl got=%b%b exp=00", Ofl16, Ofl5); end
`endif
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_basic;
    do_op16(16'h0001, 16'h0001, 1'b0, 1'b0);
    total++;
    if (Sum16 !== 16'h0002 || Cout16 !== 1'b0) begin bad++; $display("FAIL basic got=%b_%h exp=0_0002", Cout16, Sum16); end
  endtask

  task automatic test_carry;
    do_op16(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    total++;
    if (Sum16 !== 16'h0000 || Cout16 !== 1'b1) begin bad++; $display("FAIL carry got=%b_%h exp=1_0000", Cout16, Sum16); end
    do_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    total++;
    if (Sum16 !== 16'h8000 || Cout16 !== 1'b0) begin bad++; $display("FAIL ovf got=%b_%h exp=0_8000", Cout16, Sum16); end
`ifdef SERIAL_ADD_OVF_EN
    total++;
    if (Ofl16 !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", Ofl16); end
`endif
  endtask

  task automatic test_ignore_start;
    do_op16(16'h1234, 16'h1111, 1'b0, 1'b1);
    total++;
    if (Sum16 !== 16'h2345) begin bad++; $display("FAIL ignore got=%h exp=2345", Sum16); end
  endtask

  task automatic test_reset_abort;
    do_op16(16'h0005, 16'h0006, 1'b0, 1'b0);
    A16 = 16'h00F0; B16 = 16'h000F; C16 = 1'b0; start16 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start16 = 1'b0;
    end
    total++;
    if (busy16 !== 1'b1) begin bad++; $display("FAIL abort_pre got=%b exp=1", busy16); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({busy16, done16, Cout16, Sum16} !== 19'd0) begin bad++; $display("FAIL abort got=%b%b%b_%h exp=000_0000", busy16, done16, Cout16, Sum16); end
    prev16 = '0;
    prev5  = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (done16 !== 1'b0 || busy16 !== 1'b0) begin bad++; $display("FAIL abort_quiet i=%0d got=%b%b exp=00", i, busy16, done16); end
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op16(16'h0003, 16'h0004, 1'b0, 1'b0);
    total++;
    if (Sum16 !== 16'h0007) begin bad++; $display("FAIL after_abort got=%h exp=0007", Sum16); end
  endtask

  task automatic test_random16;
    for (int i = 0; i < 1000; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom), bit'(i % 2));
  endtask

  task automatic test_random5;
    do_op5(5'h1F, 5'h00, 1'b1, 1'b0);
    do_op5(5'h0F, 5'h01, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++)
      do_op5(5'($urandom), 5'($urandom), 1'($urandom), bit'(i % 2));
  endtask

  initial begin
    rst = 1'b1; start16 = 1'b0; start5 = 1'b0;
    A16 = '0; B16 = '0; C16 = 1'b0; A5 = '0; B5 = '0; C5 = 1'b0;
    test_reset;
    test_basic;
    test_carry;
    test_ignore_start;
    test_reset_abort;
    test_random16;
    test_random5;
    total++;
    if (q16.size() != 0 || q5.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d exp=0", q16.size() + q5.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
